// File: rtl/router_tx_pkg.sv
// Shared types and constants for the router packet transmitter.
// The state enum, header layout, default error window and LFSR taps live here.
package router_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEADER   = 3'd1,
    PAYLOAD  = 3'd2,
    PARITY   = 3'd3,
    WAIT_ERR = 3'd4
  } state_t;

  // Header byte as seen on data_in: length in the upper six bits, port in the lower two.
  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  localparam int          ERR_WAIT_DEF = 3;
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;

  // Fibonacci step for x^8+x^6+x^5+x^4+1: shift left, feedback from bits 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/router_tx_pgen.sv
// Payload byte generator with running parity over header and payload.
// ROUTER_TX_LFSR_EN selects an LFSR sequence; otherwise bytes count up from the seed.
module router_tx_pgen
  import router_tx_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic [7:0] seed_i,
  input  logic [7:0] hdr_i,
  output logic [7:0] byte_o,
  output logic [7:0] next_o,
  output logic [7:0] par_o
);

  logic [7:0] byte_q;
  logic [7:0] par_q;
  logic [7:0] seed_fix;

`ifdef ROUTER_TX_LFSR_EN
  // An all-zero LFSR would lock up, so a zero seed starts from 0x01.
  assign seed_fix = (seed_i == 8'h00) ? 8'h01 : seed_i;
  assign next_o   = lfsr_next(byte_q);
`else
  assign seed_fix = seed_i;
  assign next_o   = byte_q + 8'd1;
`endif

  assign byte_o = byte_q;
  // Parity including the byte currently presented.
  assign par_o  = par_q ^ byte_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      byte_q <= 8'h00;
      par_q  <= 8'h00;
    end else if (load_i) begin
      byte_q <= seed_fix;
      par_q  <= hdr_i;
    end else if (adv_i) begin
      byte_q <= next_o;
      par_q  <= par_q ^ byte_q;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter driving a byte-wide router port: header, payload, parity,
// then an error-sampling window. Payload style set by ROUTER_TX_LFSR_EN.
//
// state    | meaning
// IDLE     | ready for a request; data_in and pkt_valid are 0
// HEADER   | header byte on data_in, waiting for a non-busy edge
// PAYLOAD  | payload bytes on data_in, beat_q counts bytes left
// PARITY   | parity byte on data_in with pkt_valid low
// WAIT_ERR | ERR_WAIT cycles sampling the router error flag
module router_pkt_tx
  import router_tx_pkg::*;
#(
  parameter int ERR_WAIT = ERR_WAIT_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  logic [5:0]  req_len,
  input  logic [7:0]  req_seed,
  input  logic        req_bad_par,
  input  logic        busy,
  input  logic        error,
  output logic [7:0]  data_in,
  output logic        pkt_valid,
  output logic        done,
  output logic        err_flag,
  output logic [15:0] pkt_cnt
);

  state_t      state_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] cnt_q;
  logic [5:0]  beat_q;
  logic [3:0]  wait_q;
  logic        bad_q;

  hdr_t        hdr;
  logic        reject;
  logic        pg_load;
  logic        pg_adv;
  logic [7:0]  pg_byte;
  logic [7:0]  pg_next;
  logic [7:0]  pg_par;

  assign hdr       = '{len: req_len, addr: req_addr};
  assign reject    = (req_addr == 2'd3) || (req_len == 6'd0);
  assign req_ready = (state_q == IDLE);
  assign pg_load   = req_ready && req_valid && !reject;
  assign pg_adv    = (state_q == PAYLOAD) && !busy;

  router_tx_pgen u_pgen (
    .clock  (clock),
    .resetn (resetn),
    .load_i (pg_load),
    .adv_i  (pg_adv),
    .seed_i (req_seed),
    .hdr_i  (hdr),
    .byte_o (pg_byte),
    .next_o (pg_next),
    .par_o  (pg_par)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0000;
      beat_q  <= 6'd0;
      wait_q  <= 4'd0;
      bad_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (reject) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              data_q  <= hdr;
              valid_q <= 1'b1;
              err_q   <= 1'b0;
              bad_q   <= req_bad_par;
              beat_q  <= req_len;
              state_q <= HEADER;
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            data_q  <= pg_byte;
            state_q <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            beat_q <= beat_q - 6'd1;
            if (beat_q == 6'd1) begin
              data_q  <= pg_par ^ {8{bad_q}};
              valid_q <= 1'b0;
              state_q <= PARITY;
            end else begin
              data_q <= pg_next;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            data_q  <= 8'h00;
            wait_q  <= 4'(ERR_WAIT);
            state_q <= WAIT_ERR;
          end
        end
        WAIT_ERR: begin
          if (error) err_q <= 1'b1;
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) begin
            done_q  <= 1'b1;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_in   = data_q;
  assign pkt_valid = valid_q;
  assign done      = done_q;
  assign err_flag  = err_q;
  assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a transaction-level byte-stream model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_router_pkt_tx;

  localparam int ERR_WAIT = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_addr = 2'd0;
  logic [5:0]  req_len = 6'd0;
  logic [7:0]  req_seed = 8'h00;
  logic        req_bad_par = 1'b0;
  logic        busy = 1'b0;
  logic        error = 1'b0;
  logic [7:0]  data_in;
  logic        pkt_valid;
  logic        done;
  logic        err_flag;
  logic [15:0] pkt_cnt;

  int errors = 0;
  int checks = 0;

  router_pkt_tx #(.ERR_WAIT(ERR_WAIT)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_seed    (req_seed),
    .req_bad_par (req_bad_par),
    .busy        (busy),
    .error       (error),
    .data_in     (data_in),
    .pkt_valid   (pkt_valid),
    .done        (done),
    .err_flag    (err_flag),
    .pkt_cnt     (pkt_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Payload byte i of a packet started from seed.
  function automatic logic [7:0] pay(input logic [7:0] seed, input int i);
`ifdef ROUTER_TX_LFSR_EN
    logic [7:0] b = (seed == 8'h00) ? 8'h01 : seed;
    for (int k = 0; k < i; k++) b = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
    return b;
`else
    return seed + 8'(i);
`endif
  endfunction

  // Model: the packet is a queue of bytes still to present; the front byte is
  // popped whenever the router is not busy.
  logic [7:0]  m_q[$];
  logic [7:0]  m_data = 8'h00;
  logic        m_valid = 1'b0;
  logic        m_idle = 1'b1;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt = 16'h0000;
  logic        m_waiting = 1'b0;
  int          m_wait = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_q.delete();
      m_data = 8'h00; m_valid = 1'b0; m_idle = 1'b1; m_done = 1'b0;
      m_err = 1'b0; m_cnt = 16'h0000; m_waiting = 1'b0; m_wait = 0;
    end else begin
      m_done = 1'b0;
      if (m_idle) begin
        if (req_valid) begin
          if (req_addr == 2'd3 || req_len == 6'd0) begin
            m_done = 1'b1;
            m_err  = 1'b1;
          end else begin
            logic [7:0] par;
            par = {req_len, req_addr};
            m_q.delete();
            for (int i = 0; i < int'(req_len); i++) begin
              m_q.push_back(pay(req_seed, i));
              par = par ^ pay(req_seed, i);
            end
            m_q.push_back(req_bad_par ? ~par : par);
            m_data = {req_len, req_addr};
            m_valid = 1'b1;
            m_err = 1'b0;
            m_idle = 1'b0;
            m_waiting = 1'b0;
          end
        end
      end else if (m_waiting) begin
        if (error) m_err = 1'b1;
        m_wait--;
        if (m_wait == 0) begin
          m_waiting = 1'b0;
          m_idle = 1'b1;
          m_done = 1'b1;
          m_cnt = m_cnt + 16'd1;
        end
      end else if (!busy) begin
        if (m_q.size() > 0) begin
          m_data = m_q.pop_front();
          m_valid = (m_q.size() > 0);
        end else begin
          m_data = 8'h00;
          m_valid = 1'b0;
          m_waiting = 1'b1;
          m_wait = ERR_WAIT;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("m_ready", 16'(req_ready), 16'(m_idle));
    chk("m_data", 16'(data_in), 16'(m_data));
    chk("m_valid", 16'(pkt_valid), 16'(m_valid));
    chk("m_done", 16'(done), 16'(m_done));
    chk("m_err", 16'(err_flag), 16'(m_err));
    chk("m_cnt", pkt_cnt, m_cnt);
  end

  task automatic send_req(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                          input logic b);
    req_addr = a; req_len = l; req_seed = s; req_bad_par = b; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 60);
    if (!done) chk("done_timeout", 16'(done), 16'd1);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_data", 16'(data_in), 16'h0);
    chk("rst_cnt", pkt_cnt, 16'h0);
    resetn = 1'b1;
    #1 chk("rst_ready", 16'(req_ready), 16'd1);
    @(negedge clock);

    // nominal packet
    send_req(2'd1, 6'd5, 8'h10, 1'b0);
    chk("t1_hdr", 16'(data_in), 16'h15);
    chk("t1_hdr_v", 16'(pkt_valid), 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t1_pay", 16'(data_in), 16'h10 + 16'(i));
    end
    @(negedge clock);
    chk("t1_par", 16'(data_in), 16'h01);
    chk("t1_par_v", 16'(pkt_valid), 16'd0);
    wait_done(n);
    chk("t1_lat", 16'(n), 16'(ERR_WAIT + 1));
    chk("t1_err", 16'(err_flag), 16'd0);
    chk("t1_cnt", pkt_cnt, 16'd1);

    // busy stall on payload byte 2
    send_req(2'd1, 6'd5, 8'h10, 1'b0);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("t2_b2", 16'(data_in), 16'h12);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t2_hold", 16'(data_in), 16'h12);
    end
    busy = 1'b0;
    @(negedge clock);
    chk("t2_b3", 16'(data_in), 16'h13);
    @(negedge clock);
    chk("t2_b4", 16'(data_in), 16'h14);
    @(negedge clock);
    chk("t2_par", 16'(data_in), 16'h01);
    wait_done(n);
    chk("t2_cnt", pkt_cnt, 16'd2);

    // bad parity with router error in the window
    send_req(2'd1, 6'd5, 8'h10, 1'b1);
    repeat (5) @(negedge clock);
    @(negedge clock);
    chk("t3_par", 16'(data_in), 16'hFE);
    @(negedge clock);
    @(negedge clock);
    error = 1'b1;
    @(negedge clock);
    error = 1'b0;
    wait_done(n);
    chk("t3_err", 16'(err_flag), 16'd1);
    chk("t3_cnt", pkt_cnt, 16'd3);
    @(negedge clock);
    chk("t3_err_hold", 16'(err_flag), 16'd1);
    chk("t3_done_pulse", 16'(done), 16'd0);

    // rejected requests
    send_req(2'd3, 6'd4, 8'h00, 1'b0);
    chk("t4_done", 16'(done), 16'd1);
    chk("t4_err", 16'(err_flag), 16'd1);
    chk("t4_valid", 16'(pkt_valid), 16'd0);
    chk("t4_cnt", pkt_cnt, 16'd3);
    @(negedge clock);
    send_req(2'd2, 6'd0, 8'h00, 1'b0);
    chk("t4_len0_done", 16'(done), 16'd1);
    chk("t4_len0_ready", 16'(req_ready), 16'd1);
    @(negedge clock);

    // reset in the middle of the payload
    send_req(2'd0, 6'd10, 8'h20, 1'b0);
    repeat (4) @(negedge clock);
    chk("t5_b3", 16'(data_in), 16'h23);
    #2 resetn = 1'b0;
    #1;
    chk("t5_data", 16'(data_in), 16'h0);
    chk("t5_valid", 16'(pkt_valid), 16'd0);
    chk("t5_cnt", pkt_cnt, 16'h0);
    chk("t5_done", 16'(done), 16'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1 chk("t5_ready", 16'(req_ready), 16'd1);
    send_req(2'd2, 6'd1, 8'h77, 1'b0);
    chk("t5_hdr", 16'(data_in), 16'h06);
    @(negedge clock);
    chk("t5_pay", 16'(data_in), 16'h77);
    @(negedge clock);
    chk("t5_par", 16'(data_in), 16'h71);
    wait_done(n);
    chk("t5_cnt1", pkt_cnt, 16'd1);

    // back-to-back with req_valid held
    req_addr = 2'd0; req_len = 6'd2; req_seed = 8'hA0; req_bad_par = 1'b0;
    req_valid = 1'b1;
    wait_done(n);
    chk("t6_cnt_a", pkt_cnt, 16'd2);
    @(negedge clock);
    chk("t6_hdr2", 16'(data_in), 16'h08);
    chk("t6_hdr2_v", 16'(pkt_valid), 16'd1);
    wait_done(n);
    req_valid = 1'b0;
    chk("t6_cnt_b", pkt_cnt, 16'd3);
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
